cv32e40p_alu_fault_manager_ft: RTL

CV32E40P_ALU_FAULT_MANAGER_FT -- requirements
Module: cv32e40p_alu_fault_manager_ft

---
 rtl/cv32e40p_alu_fault_manager_ft.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_alu_fault_manager_ft.sv
// rtl/cv32e40p_alu_fault_manager_ft.sv - TMR ALU fault tracking with spare-replica swap (optional decay: FT_ALU_ERR_DECAY_EN)
module cv32e40p_alu_fault_manager_ft #(
    parameter int ERR_THRESHOLD = 4,
    parameter int DECAY_OPS     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        ex_ready_i,
    input  logic [3:0]  error_detected_i,
    input  logic        clear_i,
    output logic [2:0]  sel_mux_ex_o,
    output logic [3:0]  clock_en_o,
    output logic [3:0]  permanent_faulty_alu_o,
    output logic [3:0]  perf_counter_permanent_faulty_alu_o,
    output logic        tmr_lost_o,
    output logic [15:0] err_count_o
);

    typedef enum logic [1:0] {
        HEALTHY = 2'd0,
        SUSPECT = 2'd1,
        FAULTY  = 2'd2
    } alu_state_e;

    alu_state_e state_q [4];
    alu_state_e state_d [4];
    logic [3:0] err_q   [4];
    logic [3:0] err_d   [4];
`ifdef FT_ALU_ERR_DECAY_EN
    logic [7:0] clean_q [4];
    logic [7:0] clean_d [4];
`endif

    logic [3:0] new_fault;
    logic [2:0] sel_q;
    logic [3:0] cen_q;
    logic [3:0] perf_q;
    logic       tmr_q;
    logic       pending_q;
    logic       armed_q;
    logic       spare_used_q;
    logic [2:0] swap_mask_q;
    logic [2:0] low_mask;
    logic       multi_fault;
    logic       spare_claimed;

    // Per-ALU next state: count errors/clean ops only on active, non-faulty replicas.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k]   = state_q[k];
            err_d[k]     = err_q[k];
            new_fault[k] = 1'b0;
`ifdef FT_ALU_ERR_DECAY_EN
            clean_d[k]   = clean_q[k];
`endif
            if (enable_i && cen_q[k] && (state_q[k] != FAULTY)) begin
                if (error_detected_i[k]) begin
                    if (err_q[k] != 4'hF) begin
                        err_d[k] = err_q[k] + 4'd1;
                    end
`ifdef FT_ALU_ERR_DECAY_EN
                    clean_d[k] = 8'd0;
`endif
                    if (err_d[k] >= 4'(ERR_THRESHOLD)) begin
                        state_d[k]   = FAULTY;
                        new_fault[k] = 1'b1;
                    end else begin
                        state_d[k] = SUSPECT;
                    end
                end
`ifdef FT_ALU_ERR_DECAY_EN
                else if (clean_q[k] == 8'(DECAY_OPS - 1)) begin
                    clean_d[k] = 8'd0;
                    if (err_q[k] != 4'd0) begin
                        err_d[k] = err_q[k] - 4'd1;
                        if (err_q[k] == 4'd1) begin
                            state_d[k] = HEALTHY;
                        end
                    end
                end else begin
                    clean_d[k] = clean_q[k] + 8'd1;
                end
`endif
            end
        end
    end

    // Per-ALU state and counter registers; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n || clear_i) begin
                state_q[k] <= HEALTHY;
                err_q[k]   <= 4'd0;
`ifdef FT_ALU_ERR_DECAY_EN
                clean_q[k] <= 8'd0;
`endif
            end else begin
                state_q[k] <= state_d[k];
                err_q[k]   <= err_d[k];
`ifdef FT_ALU_ERR_DECAY_EN
                clean_q[k] <= clean_d[k];
`endif
            end
        end
    end

    // Pick the lowest newly faulty primary ALU and note simultaneous primary faults.
    always_comb begin
        low_mask = 3'b000;
        if (new_fault[0]) begin
            low_mask = 3'b001;
        end else if (new_fault[1]) begin
            low_mask = 3'b010;
        end else if (new_fault[2]) begin
            low_mask = 3'b100;
        end
        multi_fault   = ((new_fault[2:0] & (new_fault[2:0] - 3'd1)) != 3'd0);
        spare_claimed = spare_used_q || pending_q || (state_q[3] == FAULTY);
    end

    // Swap sequencing: a pending swap arms on the first ex_ready cycle and lands one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            sel_q        <= 3'b111;
            cen_q        <= 4'b0111;
            perf_q       <= 4'b0000;
            tmr_q        <= 1'b0;
            pending_q    <= 1'b0;
            armed_q      <= 1'b0;
            spare_used_q <= 1'b0;
            swap_mask_q  <= 3'b000;
        end else begin
            perf_q <= new_fault;
            if (new_fault[2:0] != 3'b000) begin
                if (!spare_claimed) begin
                    pending_q   <= 1'b1;
                    armed_q     <= ex_ready_i;
                    swap_mask_q <= low_mask;
                    if (multi_fault) begin
                        tmr_q <= 1'b1;
                    end
                end else begin
                    tmr_q <= 1'b1;
                end
            end
            if (new_fault[3]) begin
                tmr_q <= 1'b1;
            end
            if (pending_q) begin
                if (armed_q) begin
                    sel_q        <= sel_q & ~swap_mask_q;
                    cen_q        <= (cen_q & ~{1'b0, swap_mask_q}) | 4'b1000;
                    spare_used_q <= 1'b1;
                    pending_q    <= 1'b0;
                    armed_q      <= 1'b0;
                end else if (ex_ready_i) begin
                    armed_q <= 1'b1;
                end
            end
        end
    end

    // Output mapping from registered state.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            permanent_faulty_alu_o[k] = (state_q[k] == FAULTY);
        end
    end

    assign sel_mux_ex_o                        = sel_q;
    assign clock_en_o                          = cen_q;
    assign perf_counter_permanent_faulty_alu_o = perf_q;
    assign tmr_lost_o                          = tmr_q;
    assign err_count_o                         = {err_q[3], err_q[2], err_q[1], err_q[0]};

endmodule
